// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   Single-outstanding APB master bridging a simple CPU request strobe onto
//   five APB slaves. Slave n occupies the 4 KiB page BASE_ADDR[31:12] + n.
//   Any other address is unmapped. An unmapped access completes with an error
//   and drives no PSELx.
//
// Parameters
//   BASE_ADDR    base of the five-page peripheral window
//   TIMEOUT_CYC  ACCESS stall limit (only used when APB_TIMEOUT_EN is defined)
//
// Build option
//   APB_TIMEOUT_EN  when defined, a stalled ACCESS phase is abandoned with
//                   ready=1/err=1 after TIMEOUT_CYC cycles without PREADY.
//
// Ports
//   PCLK, PRESET          clock (rising edge), async active-high reset
//   transfer/write/addr/wdata   CPU request, sampled only in IDLE
//   rdata/ready/err       CPU completion (ready is a one-cycle pulse)
//   PADDR/PWDATA/PWRITE/PENABLE, PSEL0..4       APB request signals
//   PRDATA0..4, PREADY0..4                      APB slave responses
// -----------------------------------------------------------------------------
module apb_master #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        transfer,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic        PWRITE,
   output logic        PENABLE,
   output logic        PSEL0,
   output logic        PSEL1,
   output logic        PSEL2,
   output logic        PSEL3,
   output logic        PSEL4,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic [31:0] PRDATA4,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3,
   input  logic        PREADY4
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t      state;
   logic [4:0]  psel;
   logic [2:0]  sel_idx;
   logic        mapped;

   logic [19:0] page_off;
   logic        hit;
   logic [2:0]  hit_idx;
   logic        pready_sel;
   logic [31:0] prdata_sel;
   logic        done_ok;
   logic        timeout_hit;

   // Page offset from the window base; wraps modulo 2^20 so the window may
   // straddle the top of the address space just like BASE_ADDR[31:12] + n.
   always_comb begin
      page_off = addr[31:12] - BASE_ADDR[31:12];
      hit      = (page_off < 20'd5);
      hit_idx  = page_off[2:0];
   end

   // Only the latched slave's response is ever looked at.
   always_comb begin
      pready_sel = 1'b0;
      prdata_sel = '0;
      case (sel_idx)
         3'd0: begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
         3'd1: begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
         3'd2: begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
         3'd3: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
         3'd4: begin pready_sel = PREADY4; prdata_sel = PRDATA4; end
         default: begin pready_sel = 1'b0; prdata_sel = '0; end
      endcase
   end

`ifdef APB_TIMEOUT_EN
   // Counts ACCESS cycles that ended without PREADY from the selected slave.
   logic [31:0] to_cnt;

   always_comb begin
      timeout_hit = (state == ACCESS) && mapped && !pready_sel &&
                    (to_cnt == TIMEOUT_CYC);
   end
`else
   always_comb begin
      timeout_hit = 1'b0;
   end
`endif

   // Completion is combinational in the ACCESS cycle; a decode miss needs no
   // slave and finishes in the first ACCESS cycle.
   always_comb begin
      done_ok = (state == ACCESS) && (!mapped || pready_sel);
      ready   = done_ok || timeout_hit;
      err     = ((state == ACCESS) && !mapped) || timeout_hit;
      rdata   = (done_ok && mapped && !PWRITE) ? prdata_sel : '0;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= IDLE;
         psel    <= '0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PADDR   <= '0;
         PWDATA  <= '0;
         sel_idx <= '0;
         mapped  <= 1'b0;
`ifdef APB_TIMEOUT_EN
         to_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (transfer) begin
                  PADDR   <= addr;
                  PWDATA  <= wdata;
                  PWRITE  <= write;
                  sel_idx <= hit ? hit_idx : 3'd0;
                  mapped  <= hit;
                  psel    <= hit ? (5'b00001 << hit_idx) : 5'b00000;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               to_cnt  <= '0;
`endif
            end
            ACCESS: begin
               if (ready) begin
                  psel    <= '0;
                  PENABLE <= 1'b0;
                  state   <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + 32'd1;
               end
`endif
            end
            default: begin
               psel    <= '0;
               PENABLE <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign PSEL0 = psel[0];
   assign PSEL1 = psel[1];
   assign PSEL2 = psel[2];
   assign PSEL3 = psel[3];
   assign PSEL4 = psel[4];

endmodule

// File: tb/tb_apb_master.sv
`timescale 1ns/1ps
module tb_apb_master;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int unsigned TO   = 4;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        transfer = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata, PADDR, PWDATA;
   logic        ready, err, PWRITE, PENABLE;
   logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
   logic [4:0]  psel_v;
   logic [4:0]  pready = '0;
   logic [31:0] prdata [5];

   int tests = 0;
   int fails = 0;
   bit rand_slaves = 1'b0;

   always #5 PCLK = ~PCLK;

   assign psel_v = {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};

   apb_master #(.BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
      .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4),
      .PRDATA0(prdata[0]), .PRDATA1(prdata[1]), .PRDATA2(prdata[2]),
      .PRDATA3(prdata[3]), .PRDATA4(prdata[4]),
      .PREADY0(pready[0]), .PREADY1(pready[1]), .PREADY2(pready[2]),
      .PREADY3(pready[3]), .PREADY4(pready[4])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Transaction-level reference: one outstanding request, k counts cycles
   // since acceptance (1 = setup, >=2 = access). Checked every negedge.
   // ---------------------------------------------------------------------
   bit          m_busy = 1'b0;
   int          m_k = 0;
   bit          m_map = 1'b0;
   int          m_idx = 0;
   bit          m_wr = 1'b0;
   logic [31:0] l_addr = '0, l_wdata = '0;
   logic        l_write = 1'b0;

   always @(negedge PCLK) begin : model
      logic [4:0]  e_psel;
      logic        e_pen, e_rdy, e_err, d_ok, t_o;
      logic [31:0] e_rd, off;
      if (PRESET) begin
         m_busy = 1'b0; l_addr = '0; l_wdata = '0; l_write = 1'b0;
      end
      e_psel = (m_busy && m_map) ? 5'(1 << m_idx) : 5'd0;
      e_pen  = m_busy && (m_k >= 2);
      d_ok   = e_pen && (!m_map || pready[m_idx] === 1'b1);
`ifdef APB_TIMEOUT_EN
      t_o    = e_pen && m_map && pready[m_idx] !== 1'b1 && (m_k - 2 == int'(TO));
`else
      t_o    = 1'b0;
`endif
      e_rdy  = d_ok || t_o;
      e_err  = e_rdy && (!m_map || t_o);
      e_rd   = (d_ok && m_map && !m_wr) ? prdata[m_idx] : 32'd0;
      check("psel",    {27'd0, psel_v}, {27'd0, e_psel});
      check("penable", {31'd0, PENABLE}, {31'd0, e_pen});
      check("ready",   {31'd0, ready}, {31'd0, e_rdy});
      check("err",     {31'd0, err}, {31'd0, e_err});
      check("rdata",   rdata, e_rd);
      check("paddr",   PADDR, l_addr);
      check("pwdata",  PWDATA, l_wdata);
      check("pwrite",  {31'd0, PWRITE}, {31'd0, l_write});
      if (!PRESET) begin
         if (m_busy) begin
            if (e_rdy) m_busy = 1'b0;
            else m_k++;
         end else if (transfer) begin
            off = {12'd0, addr[31:12] - BASE[31:12]};
            m_busy = 1'b1; m_k = 1;
            m_map = (off < 32'd5);
            m_idx = m_map ? int'(off) : 0;
            m_wr = write;
            l_addr = addr; l_wdata = wdata; l_write = write;
         end
      end
   end

   task automatic rand_slv();
      for (int i = 0; i < 5; i++) begin
         pready[i] = ($urandom_range(0, 2) == 0);
         prdata[i] = $urandom;
      end
   endtask

   task automatic step();
      @(posedge PCLK); #1;
      if (rand_slaves) rand_slv();
   endtask

   // Called 1 ns after a rising edge. Holds the request until ready or until
   // maxc cycles elapse (lat = -1). Directed mode: selected slave raises PREADY
   // stall cycles after the first ACCESS cycle; noise drives other PREADYs.
   task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int stall, input int maxc,
                         input bit pulse, input logic [4:0] noise,
                         output int lat, output logic e_seen,
                         output logic [31:0] r_seen, output logic [4:0] psel1);
      int sel;
      logic [19:0] off;
      off = a[31:12] - BASE[31:12];
      sel = (off < 20'd5) ? int'(off) : -1;
      transfer = 1'b1; write = w; addr = a; wdata = d;
      lat = -1; e_seen = 1'b0; r_seen = '0; psel1 = '0;
      for (int n = 0; n < maxc && lat < 0; n++) begin
         if (!rand_slaves) begin
            for (int i = 0; i < 5; i++) prdata[i] = 32'hDEAD_0000 | i;
            pready = noise;
            if (sel >= 0) begin
               prdata[sel] = rd;
               if (n >= 2 + stall) pready[sel] = 1'b1;
            end
            if (pulse && n >= 1) transfer = n[0];
         end else if (n >= 1) begin
            addr = $urandom; wdata = $urandom; write = $urandom_range(0, 1);
         end
         @(negedge PCLK);
         if (n == 1) psel1 = psel_v;
         if (ready) begin lat = n; e_seen = err; r_seen = rdata; end
         step();
      end
      transfer = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int lat;
      logic e;
      logic [31:0] r, a;
      logic [4:0] p1;
      for (int i = 0; i < 5; i++) prdata[i] = '0;

      // reset values while PRESET is held
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_psel", {27'd0, psel_v}, 32'd0);
      check("rst_paddr", PADDR, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      step();

      // write to slave 2, PREADY one cycle after PENABLE
      do_txn(1'b1, 32'h1000_2008, 32'h55, 32'h0, 1, 50, 1'b0, 5'b0, lat, e, r, p1);
      check("wr2_lat", lat, 32'd3);
      check("wr2_err", {31'd0, e}, 32'd0);
      check("wr2_rdata", r, 32'd0);
      check("wr2_psel_setup", {27'd0, p1}, 32'h4);
      check("wr2_pwdata", PWDATA, 32'h55);

      // zero-wait read from slave 3
      do_txn(1'b0, 32'h1000_300C, 32'h0, 32'hA5, 0, 50, 1'b0, 5'b0, lat, e, r, p1);
      check("rd3_lat", lat, 32'd2);
      check("rd3_rdata", r, 32'h0000_00A5);
      check("rd3_err", {31'd0, e}, 32'd0);
      @(negedge PCLK);
      check("rd3_psel_after", {31'd0, PSEL3}, 32'd0);
      step();

      // unmapped read
      do_txn(1'b0, 32'h2000_0000, 32'h0, 32'h77, 0, 50, 1'b0, 5'b11111, lat, e, r, p1);
      check("unmap_lat", lat, 32'd2);
      check("unmap_err", {31'd0, e}, 32'd1);
      check("unmap_rdata", r, 32'd0);
      check("unmap_psel", {27'd0, p1}, 32'd0);

      // slave 1 stalls 5 cycles, slave 0 PREADY high, transfer toggling
      do_txn(1'b0, 32'h1000_1004, 32'h0, 32'h1234_5678, 5, 50, 1'b1, 5'b00001, lat, e, r, p1);
      check("stall_lat", lat, 32'd7);
      check("stall_rdata", r, 32'h1234_5678);
      check("stall_paddr", PADDR, 32'h1000_1004);

      // reset in the middle of ACCESS
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_4000; wdata = 32'h99; pready = '0;
      step(); step();
      #2 PRESET = 1'b1;
      @(negedge PCLK);
      check("rstmid_psel", {27'd0, psel_v}, 32'd0);
      check("rstmid_pen", {31'd0, PENABLE}, 32'd0);
      check("rstmid_ready", {31'd0, ready}, 32'd0);
      check("rstmid_paddr", PADDR, 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0; transfer = 1'b0;
      step();
      do_txn(1'b0, 32'h1000_4010, 32'h0, 32'hCAFE, 2, 50, 1'b0, 5'b0, lat, e, r, p1);
      check("after_rst_lat", lat, 32'd4);
      check("after_rst_rdata", r, 32'hCAFE);

      // slave 0 never ready
`ifdef APB_TIMEOUT_EN
      do_txn(1'b0, 32'h1000_0000, 32'h0, 32'h0, 100000, 50, 1'b0, 5'b0, lat, e, r, p1);
      check("timeout_lat", lat, 32'(2 + TO));
      check("timeout_err", {31'd0, e}, 32'd1);
      check("timeout_rdata", r, 32'd0);
`else
      do_txn(1'b0, 32'h1000_0000, 32'h0, 32'h0, 100000, 302, 1'b0, 5'b0, lat, e, r, p1);
      check("no_timeout", lat, 32'hFFFF_FFFF);
      PRESET = 1'b1;
      step();
      PRESET = 1'b0;
      step();
`endif

      // randomized traffic
      rand_slaves = 1'b1;
      rand_slv();
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 7) == 0) a = $urandom;
         else a = BASE + (32'($urandom_range(0, 6)) << 12) + 32'($urandom_range(0, 4095));
         do_txn(1'($urandom_range(0, 1)), a, $urandom, 32'h0, 0, 400, 1'b0, 5'b0,
                lat, e, r, p1);
         check("rand_done", {31'd0, (lat >= 0)}, 32'd1);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
